// File: rtl/murax_led_arbiter.sv
// LED ownership arbiter for the Murax board: heartbeat / CPU GPIO / button-press counter,
// plus 2-flop synchronizers and debouncers for BUT1/BUT2.
module murax_led_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HEARTBEAT_BITS  = 24
) (
    input  logic       io_mainClk,
    input  logic       io_reset,
    input  logic       io_but1Raw,
    input  logic       io_but2Raw,
    input  logic [3:0] io_cpuLeds,
    input  logic [3:0] io_cpuLedsEn,
    input  logic       io_cpuClaim,
    output logic [3:0] io_leds,
    output logic [1:0] io_owner,
    output logic [1:0] io_buttons,
    output logic       io_but1Press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StHeart  = 2'd0,
        StCpu    = 2'd1,
        StButton = 2'd2
    } owner_e;

    logic [1:0]                sync1_q;
    logic [1:0]                sync2_q;
    logic [1:0]                level_q;
    logic [1:0]                press_q;
    logic [CntW-1:0]           db_cnt_q [2];
    logic [HEARTBEAT_BITS-1:0] hb_q;
    logic [3:0]                press_cnt_q;
    logic [3:0]                leds_q;
    logic [3:0]                led_src;
    owner_e                    state_q;

    // Bit 0 = BUT1, bit 1 = BUT2. The press pulse is registered together with the level so
    // it lines up with the rising edge of io_buttons.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q <= {io_but2Raw, io_but1Raw};
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == level_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == CntLast) begin
                    db_cnt_q[b] <= '0;
                    level_q[b]  <= sync2_q[b];
                    press_q[b]  <= sync2_q[b];
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        led_src = 4'b0000;
        case (state_q)
            StHeart:  led_src = 4'b0001 << hb_q[HEARTBEAT_BITS-1 -: 2];
            StCpu:    led_src = io_cpuLeds & io_cpuLedsEn;
            StButton: led_src = press_cnt_q;
            default:  led_src = 4'b0000;
        endcase
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_q     <= StHeart;
            hb_q        <= '0;
            press_cnt_q <= '0;
            leds_q      <= '0;
        end else begin
            hb_q        <= hb_q + HEARTBEAT_BITS'(1);
            press_cnt_q <= press_cnt_q + {3'b000, press_q[0]};
            leds_q      <= led_src;
            // A BUT2 press outranks the claim level in every state.
            if (press_q[1]) begin
                state_q <= (state_q == StButton) ? StHeart : StButton;
            end else begin
                case (state_q)
                    StHeart:  if (io_cpuClaim) state_q <= StCpu;
                    StCpu:    if (!io_cpuClaim) state_q <= StHeart;
                    StButton: ;
                    default:  state_q <= StHeart;
                endcase
            end
        end
    end

    assign io_leds      = leds_q;
    assign io_owner     = state_q;
    assign io_buttons   = level_q;
    assign io_but1Press = press_q[0];

endmodule

// File: tb/tb_murax_led_arbiter.sv
// Self-checking bench for murax_led_arbiter: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_murax_led_arbiter;

    localparam int D  = 4;
    localparam int HB = 6;

    logic       clk;
    logic       rst;
    logic       raw1;
    logic       raw2;
    logic [3:0] cpu_leds;
    logic [3:0] cpu_en;
    logic       claim;
    logic [3:0] leds;
    logic [1:0] owner;
    logic [1:0] buttons;
    logic       but1_press;

    int n_tests = 0;
    int n_fail  = 0;
    int n_press_seen = 0;

    murax_led_arbiter #(
        .DEBOUNCE_CYCLES(D),
        .HEARTBEAT_BITS (HB)
    ) dut (
        .io_mainClk  (clk),
        .io_reset    (rst),
        .io_but1Raw  (raw1),
        .io_but2Raw  (raw2),
        .io_cpuLeds  (cpu_leds),
        .io_cpuLedsEn(cpu_en),
        .io_cpuClaim (claim),
        .io_leds     (leds),
        .io_owner    (owner),
        .io_buttons  (buttons),
        .io_but1Press(but1_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid = 1'b0;
    int m_hb, m_cnt, m_owner, m_leds;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    bit m_press [2];
    bit m_hist0 [$];
    bit m_hist1 [$];

    // Level flips once the last D synchronized samples all disagree with it.
    function automatic bit flips(input bit q[$], input bit lvl);
        if (q.size() < D) return 1'b0;
        foreach (q[i]) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit s;
        bit f;
        if (rst) begin
            m_valid = 1'b1;
            m_hb = 0; m_cnt = 0; m_owner = 0; m_leds = 0;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_press[b] = 0;
            end
            m_hist0.delete();
            m_hist1.delete();
        end else if (m_valid) begin
            case (m_owner)
                0:       m_leds = (1 << (m_hb >> (HB - 2)));
                1:       m_leds = int'(cpu_leds & cpu_en);
                default: m_leds = m_cnt;
            endcase
            m_cnt = (m_cnt + int'(m_press[0])) % 16;
            if (m_press[1]) m_owner = (m_owner == 2) ? 0 : 2;
            else if (m_owner == 0 && claim) m_owner = 1;
            else if (m_owner == 1 && !claim) m_owner = 0;
            m_hb = (m_hb + 1) % (1 << HB);
            for (int b = 0; b < 2; b++) begin
                s = m_s2[b];
                if (b == 0) begin
                    m_hist0.push_back(s);
                    if (m_hist0.size() > D) void'(m_hist0.pop_front());
                    f = flips(m_hist0, m_lvl[0]);
                end else begin
                    m_hist1.push_back(s);
                    if (m_hist1.size() > D) void'(m_hist1.pop_front());
                    f = flips(m_hist1, m_lvl[1]);
                end
                m_press[b] = f && s;
                if (f) m_lvl[b] = s;
                m_s2[b] = m_s1[b];
                m_s1[b] = (b == 0) ? raw1 : raw2;
            end
        end
    end

    always @(negedge clk) begin
        if (but1_press === 1'b1) n_press_seen++;
        if (m_valid) begin
            chk("model_leds", 32'(leds), 32'(m_leds));
            chk("model_owner", 32'(owner), 32'(m_owner));
            chk("model_buttons", 32'(buttons), 32'({m_lvl[1], m_lvl[0]}));
            chk("model_press", 32'(but1_press), 32'(m_press[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; raw1 = 1'b0; raw2 = 1'b0; claim = 1'b0;
        cyc(2);
        chk("reset_leds", 32'(leds), 32'h0);
        chk("reset_owner", 32'(owner), 32'h0);
        chk("reset_buttons", 32'(buttons), 32'h0);
        chk("reset_press", 32'(but1_press), 32'h0);
        rst = 1'b0;
    endtask

    task automatic press1();
        raw1 = 1'b1; cyc(8);
        raw1 = 1'b0; cyc(8);
    endtask

    task automatic press2();
        raw2 = 1'b1; cyc(8);
        raw2 = 1'b0; cyc(8);
    endtask

    initial begin
        int pat [5];
        int seen;
        int hold1, hold2;
        pat = '{1, 2, 4, 8, 1};
        rst = 1'b1; raw1 = 1'b0; raw2 = 1'b0; claim = 1'b0;
        cpu_leds = 4'b0000; cpu_en = 4'b0000;
        cyc(1);
        do_reset();

        // Heartbeat walks one-hot every 16 cycles and wraps back to 0001.
        for (int k = 1; k <= 65; k++) begin
            cyc(1);
            if (k % 16 == 1) chk("heartbeat", 32'(leds), 32'(pat[k / 16]));
        end
        chk("idle_owner", 32'(owner), 32'h0);

        // Short glitch is filtered, then a held press appears 6 cycles later.
        seen = n_press_seen;
        raw1 = 1'b1; cyc(2);
        raw1 = 1'b0; cyc(10);
        chk("glitch_buttons", 32'(buttons), 32'h0);
        chk("glitch_no_press", 32'(n_press_seen), 32'(seen));
        raw1 = 1'b1; cyc(5);
        chk("debounce_early", 32'(buttons[0]), 32'h0);
        cyc(1);
        chk("debounce_rise", 32'(buttons[0]), 32'h1);
        chk("press_pulse", 32'(but1_press), 32'h1);
        cyc(1);
        chk("press_single", 32'(but1_press), 32'h0);
        cyc(3);
        raw1 = 1'b0; cyc(8);

        // CPU ownership and masked LED values.
        claim = 1'b1; cpu_leds = 4'b1010; cpu_en = 4'b1110;
        cyc(1);
        chk("cpu_owner", 32'(owner), 32'h1);
        cyc(1);
        chk("cpu_leds", 32'(leds), 32'hA);
        cpu_en = 4'b0110;
        cyc(1);
        chk("cpu_leds_mask", 32'(leds), 32'h2);
        claim = 1'b0;
        cyc(1);
        chk("cpu_release", 32'(owner), 32'h0);

        // BUT2 takes over from CPU, counter shows presses, then CPU regains via HEART.
        do_reset();
        claim = 1'b1;
        cyc(1);
        chk("claim_owner", 32'(owner), 32'h1);
        raw2 = 1'b1; cyc(7);
        chk("but2_owner", 32'(owner), 32'h2);
        raw2 = 1'b0; cyc(8);
        chk("claim_ignored", 32'(owner), 32'h2);
        repeat (5) press1();
        chk("count5_leds", 32'(leds), 32'h5);
        raw2 = 1'b1; cyc(7);
        chk("but2_back_heart", 32'(owner), 32'h0);
        cyc(1);
        chk("claim_regain", 32'(owner), 32'h1);
        raw2 = 1'b0; cyc(8);

        // Counter wrap after 17 presses.
        do_reset();
        press2();
        chk("button_owner", 32'(owner), 32'h2);
        repeat (17) press1();
        chk("count_wrap", 32'(leds), 32'h1);

        // Reset mid-debounce while BUTTON owns with count 3.
        do_reset();
        press2();
        repeat (3) press1();
        chk("count3_leds", 32'(leds), 32'h3);
        raw1 = 1'b1; cyc(3);
        do_reset();
        seen = n_press_seen;
        cyc(12);
        chk("no_stray_press", 32'(n_press_seen), 32'(seen));
        raw2 = 1'b1; cyc(8);
        chk("post_reset_owner", 32'(owner), 32'h2);
        chk("post_reset_count", 32'(leds), 32'h0);
        raw2 = 1'b0; cyc(8);

        // Randomized traffic checked by the model every cycle.
        hold1 = 1; hold2 = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--hold1 == 0) begin raw1 = ~raw1; hold1 = $urandom_range(1, 12); end
            if (--hold2 == 0) begin raw2 = ~raw2; hold2 = $urandom_range(1, 20); end
            if ($urandom_range(0, 19) == 0) claim = ~claim;
            if ($urandom_range(0, 7) == 0) begin
                cpu_leds = 4'($urandom);
                cpu_en   = 4'($urandom);
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/murax_led_arbiter.md
# murax_led_arbiter

Owns the four board LEDs and the two push buttons of the Murax board top level. It shares the LEDs between three sources: a free-running heartbeat, the CPU GPIO outputs, and a local button-press counter. A small ownership state machine selects the source. The block also debounces BUT1/BUT2 and returns clean button levels for the CPU's GPIO read port. It sits between the board pins and the Murax instance, in the `io_mainClk` domain after the PLL.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level changes (≥2).
- HEARTBEAT_BITS, 24: width of the heartbeat counter (≥3).

Ports (one clock; reset is synchronous and active-high):
- io_mainClk  in  1  system clock (PLL output).
- io_reset  in  1  synchronous active-high reset.
- io_but1Raw  in  1  raw BUT1 pin, 1 = pressed, asynchronous.
- io_but2Raw  in  1  raw BUT2 pin, 1 = pressed, asynchronous.
- io_cpuLeds  in  4  CPU LED values (GPIO write bits 0,1,2,7).
- io_cpuLedsEn  in  4  matching GPIO writeEnable bits.
- io_cpuClaim  in  1  CPU requests LED ownership (level).
- io_leds  out  4  LED drive, 1 = on.
- io_owner  out  2  current owner: 0 = HEART, 1 = CPU, 2 = BUTTON (3 unused).
- io_buttons  out  2  debounced levels {but2, but1}, for GPIO read.
- io_but1Press  out  1  one-cycle pulse on each debounced BUT1 press.

## Operation
- Input path per button: 2-flop synchronizer, then debouncer. The debouncer holds a counter that clears whenever the synchronized value equals the debounced level. When the value differs for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears. A glitch shorter than DEBOUNCE_CYCLES is never seen.
- Press event: a debounced 0→1 transition gives a single-cycle pulse. The BUT1 pulse drives io_but1Press. The BUT2 pulse is internal. Releases give no event.
- Heartbeat: an HEARTBEAT_BITS counter increments every cycle and wraps to 0. The pattern is one-hot `4'b0001 << hb[MSB:MSB-1]`.
- Press counter: 4 bits. It increments on each BUT1 press event in every state and wraps 15→0. It is cleared only by reset.
- Ownership FSM, states HEART / CPU / BUTTON, reset state HEART. Priority per cycle is: BUT2 press first, then claim.
  - HEART: BUT2 press → BUTTON; otherwise io_cpuClaim=1 → CPU.
  - CPU: BUT2 press → BUTTON; otherwise io_cpuClaim=0 → HEART.
  - BUTTON: BUT2 press → HEART. io_cpuClaim is ignored. If claim is still high, the CPU regains ownership through HEART on the following cycle.
- LED source per state:
  - HEART: heartbeat pattern.
  - CPU: bit i = io_cpuLedsEn[i] & io_cpuLeds[i].
  - BUTTON: press counter value.
- io_owner is the state register encoding.

## Timing
- Reset (io_reset sampled high at a clock edge) clears everything:
  - io_leds = 0, io_owner = 0, io_buttons = 0, io_but1Press = 0.
  - Synchronizers, debounce counters, heartbeat counter and press counter all = 0.
- Reset mid-debounce or mid-press discards the partial count. No pulse is emitted.
- A raw change held stable appears on io_buttons exactly DEBOUNCE_CYCLES+2 cycles later: 2 synchronizer cycles plus DEBOUNCE_CYCLES.
- io_but1Press is asserted in the same cycle io_buttons[0] rises, for exactly 1 cycle.
- Press event → state register/io_owner updates 1 cycle later. Press counter updates in that same cycle.
- io_leds is registered: it shows the selected source's value from the previous cycle. An ownership change is visible on io_leds 1 cycle after io_owner.
- io_cpuClaim is sampled directly (already synchronous). The FSM reacts at the next edge.
- Simultaneous events in one cycle:
  - BUT2 press and claim change: BUT2 wins.
  - BUT1 and BUT2 press: both take effect, so the counter increments and the state changes.
- Heartbeat wrap from all-ones to 0 is seamless; the pattern returns to 4'b0001.

## Test plan
Run with DEBOUNCE_CYCLES=4, HEARTBEAT_BITS=6.
1. Reset, then idle 64 cycles → io_owner=0; io_leds steps 0001, 0010, 0100, 1000 every 16 cycles, then back to 0001 at wrap.
2. io_but1Raw high for 2 cycles, then low → io_buttons stays 0, no io_but1Press. Then hold high for 10 cycles → io_buttons[0]=1 at cycle 6 after the edge, with a single io_but1Press pulse that cycle.
3. io_cpuClaim=1, io_cpuLeds=4'b1010, io_cpuLedsEn=4'b1110 → io_owner=1 after 1 cycle, io_leds=4'b1010 one cycle later. io_cpuLedsEn=4'b0110 → io_leds=4'b0010. Claim=0 → owner 0.
4. Owner=CPU with claim held high; BUT2 press → owner=2 and claim is ignored. Five BUT1 presses → io_leds=4'b0101. Next BUT2 press → owner 0, then owner 1 the next cycle.
5. 17 BUT1 presses in BUTTON state → counter wraps; io_leds=4'b0001.
6. Assert io_reset mid-debounce and while owner=2 with count=3 → all outputs 0, owner 0, count 0, no stray io_but1Press after release of reset.
